// File: rtl/vgacon_text_seq.sv
// Byte-stream sequencer for the VGA console text buffer: cursor tracking,
// control-code handling and multi-cycle clear/scroll through the buffer ports.
module vgacon_text_seq #(
  parameter int COLS = 12,
  parameter int ROWS = 3,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [6:0]    buf_wdata,
  output logic [AW-1:0] buf_raddr,
  input  logic [6:0]    buf_rdata,
  output logic [3:0]    cursor_col,
  output logic [1:0]    cursor_row,
  output logic          busy
);

  localparam logic [AW-1:0] COLS_A     = AW'(COLS);
  localparam logic [AW-1:0] LAST_CELL  = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0] LAST_SRC   = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] FIRST_LAST = AW'((ROWS - 1) * COLS);
  localparam logic [3:0]    LAST_COL   = 4'(COLS - 1);
  localparam logic [1:0]    LAST_ROW   = 2'(ROWS - 1);
  localparam logic [6:0]    BLANK      = 7'h20;

  typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_BLANK} state_t;

  state_t        state_reg;
  logic [3:0]    col_reg, pend_col_reg;
  logic [1:0]    row_reg, pend_row_reg;
  logic          pend_scroll_reg;
  logic          we_reg;
  logic [AW-1:0] waddr_reg, raddr_reg, cnt_reg;
  logic [6:0]    wdata_reg;
  logic [AW-1:0] cur_addr;
  logic          printable;

  assign cur_addr  = AW'(row_reg) * COLS_A + AW'(col_reg);
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= CLEAR;
      col_reg         <= '0;
      row_reg         <= '0;
      pend_col_reg    <= '0;
      pend_row_reg    <= '0;
      pend_scroll_reg <= 1'b0;
      we_reg          <= 1'b0;
      waddr_reg       <= '0;
      wdata_reg       <= BLANK;
      raddr_reg       <= '0;
      cnt_reg         <= '0;
    end else begin
      case (state_reg)
        // we_reg low here means the clear has not issued its first write yet
        CLEAR: begin
          wdata_reg <= BLANK;
          if (!we_reg) begin
            we_reg    <= 1'b1;
            waddr_reg <= '0;
          end else if (waddr_reg == LAST_CELL) begin
            we_reg    <= 1'b0;
            state_reg <= IDLE;
          end else begin
            waddr_reg <= waddr_reg + AW'(1);
          end
        end
        IDLE: begin
          if (in_valid) begin
            state_reg       <= PUT;
            we_reg          <= 1'b0;
            pend_col_reg    <= col_reg;
            pend_row_reg    <= row_reg;
            pend_scroll_reg <= 1'b0;
            if (printable) begin
              we_reg    <= 1'b1;
              waddr_reg <= cur_addr;
              wdata_reg <= in_data[6:0];
              if (col_reg == LAST_COL) begin
                pend_col_reg <= '0;
                if (row_reg == LAST_ROW) pend_scroll_reg <= 1'b1;
                else                     pend_row_reg    <= row_reg + 2'd1;
              end else begin
                pend_col_reg <= col_reg + 4'd1;
              end
            end else begin
              case (in_data)
                8'h0A: begin
                  pend_col_reg <= '0;
                  if (row_reg != LAST_ROW) begin
                    pend_row_reg <= row_reg + 2'd1;
                  end else begin
                    col_reg   <= '0;
                    state_reg <= SCROLL_RD;
                    cnt_reg   <= '0;
                    raddr_reg <= COLS_A;
                  end
                end
                8'h0D: pend_col_reg <= '0;
                8'h08: begin
                  if (col_reg != 4'd0) begin
                    pend_col_reg <= col_reg - 4'd1;
                    we_reg       <= 1'b1;
                    waddr_reg    <= cur_addr - AW'(1);
                    wdata_reg    <= BLANK;
                  end
                end
                8'h0C: begin
                  state_reg <= CLEAR;
                  col_reg   <= '0;
                  row_reg   <= '0;
                  we_reg    <= 1'b1;
                  waddr_reg <= '0;
                  wdata_reg <= BLANK;
                end
                default: ;
              endcase
            end
          end
        end
        PUT: begin
          we_reg  <= 1'b0;
          col_reg <= pend_col_reg;
          row_reg <= pend_row_reg;
          if (pend_scroll_reg) begin
            state_reg <= SCROLL_RD;
            cnt_reg   <= '0;
            raddr_reg <= COLS_A;
          end else begin
            state_reg <= IDLE;
          end
        end
        SCROLL_RD: begin
          state_reg <= SCROLL_WR;
          we_reg    <= 1'b1;
          waddr_reg <= cnt_reg;
        end
        // Write data comes straight from buf_rdata, so only address/strobe are set here
        SCROLL_WR: begin
          if (cnt_reg == LAST_SRC) begin
            state_reg <= SCROLL_BLANK;
            waddr_reg <= FIRST_LAST;
            wdata_reg <= BLANK;
          end else begin
            state_reg <= SCROLL_RD;
            we_reg    <= 1'b0;
            cnt_reg   <= cnt_reg + AW'(1);
            raddr_reg <= cnt_reg + AW'(1) + COLS_A;
          end
        end
        SCROLL_BLANK: begin
          if (waddr_reg == LAST_CELL) begin
            we_reg    <= 1'b0;
            state_reg <= IDLE;
          end else begin
            waddr_reg <= waddr_reg + AW'(1);
          end
        end
        default: begin
          state_reg <= CLEAR;
          we_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign busy       = ~in_ready;
  assign buf_we     = we_reg;
  assign buf_waddr  = waddr_reg;
  assign buf_wdata  = (state_reg == SCROLL_WR) ? buf_rdata : wdata_reg;
  assign buf_raddr  = raddr_reg;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

endmodule
